// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, widths, clear-engine states
// and the RGB565 pixel layout used by the BRAM arbiter slice.
package fb_pkg;

    localparam int FB_HSIZE = 640;
    localparam int FB_VSIZE = 480;
    localparam int FB_NPIX  = FB_HSIZE * FB_VSIZE;
    localparam int FB_AW    = 19;
    localparam int FB_DW    = 16;

    // Explicit encodings keep the state values stable for older tools and dumps
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Frame clear engine: walks the frame address space once, writing a latched
// colour, yielding to scanout on every cycle where disp_en is high.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int AW   = FB_AW,
    parameter int DW   = FB_DW,
    parameter int NPIX = FB_NPIX
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    input  logic          disp_en,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] clr_addr,
    output logic [DW-1:0] clr_wdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    clr_state_t    state;
    logic [AW-1:0] addr;
    logic [DW-1:0] color;

    // Sequence IDLE -> CLEAR -> DONE, advancing the address only on writes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            addr  <= '0;
            color <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        addr  <= '0;
                        color <= clr_color;
                    end
                end
                CLEAR: begin
                    if (!disp_en) begin
                        if (addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign clr_busy  = (state == CLEAR);
    assign clr_done  = (state == DONE);
    assign clr_addr  = addr;
    assign clr_wdata = color;

endmodule

// File: rtl/fb_bram_arbiter.sv
// Single-port frame-buffer BRAM arbiter: scanout reads win outright, the
// clear engine fills blanking cycles, and the pixel writer gets the rest.
// Optional build macro FB_ARB_STATS_EN adds saturating stall/collision counters.
module fb_bram_arbiter
    import fb_pkg::*;
#(
    parameter int AW     = FB_AW,
    parameter int DW     = FB_DW,
    parameter int NPIX   = FB_NPIX,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          disp_en,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wdata,
    input  logic [DW-1:0] bram_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]   wr_stall_cnt,
    output logic [31:0]   disp_clr_collide_cnt
`endif
);

    // One extra bit so the bound still works when NPIX equals 2**AW
    localparam logic [AW:0] NPIX_EXT = (AW + 1)'(NPIX);

    logic [AW-1:0]     clr_addr;
    logic [DW-1:0]     clr_wdata;
    logic              wr_in_range;
    logic              wr_fire;
    logic [RD_LAT-1:0] rvalid_pipe;

    fb_clear_engine #(
        .AW   (AW),
        .DW   (DW),
        .NPIX (NPIX)
    ) u_clear (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .disp_en   (disp_en),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_addr  (clr_addr),
        .clr_wdata (clr_wdata)
    );

    assign wr_ready    = !RESET && !disp_en && !clr_busy;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < NPIX_EXT);

    // Priority mux onto the single BRAM port; everything is held off in reset
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (!RESET) begin
            if (disp_en) begin
                bram_en   = 1'b1;
                bram_addr = disp_addr;
            end else if (clr_busy) begin
                bram_en    = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = clr_addr;
                bram_wdata = clr_wdata;
            end else if (wr_valid && wr_in_range) begin
                bram_en    = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = wr_addr;
                bram_wdata = wr_data;
            end
        end
    end

    // Flag a consumed writer transfer whose address lies outside the frame
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_fire && !wr_in_range;
        end
    end

    // Delay disp_en by the BRAM read latency to mark valid scanout data
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rvalid_pipe <= '0;
        end else begin
            rvalid_pipe[0] <= disp_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rvalid_pipe[i] <= rvalid_pipe[i-1];
            end
        end
    end

    assign disp_rvalid = rvalid_pipe[RD_LAT-1];
    assign disp_rdata  = bram_rdata;

`ifdef FB_ARB_STATS_EN
    // Count writer stall cycles and scanout preemptions of an active clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_stall_cnt         <= '0;
            disp_clr_collide_cnt <= '0;
        end else begin
            if (wr_valid && !wr_ready && (wr_stall_cnt != 32'hFFFF_FFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 32'd1;
            end
            if (clr_busy && disp_en && (disp_clr_collide_cnt != 32'hFFFF_FFFF)) begin
                disp_clr_collide_cnt <= disp_clr_collide_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fb_bram_arbiter.md
Name: fb_bram_arbiter

Overview:
Single-port frame-buffer BRAM arbiter between three requesters:
- VGA scanout read stream, addressed by the upstream h/v pixel-address generator.
- A pixel writer (CPU/camera) using a valid/ready handshake.
- An internal clear engine that fills the whole frame with one colour.

Scanout has absolute priority during active video. The clear engine and the writer share the blanking cycles.

Parameters:
AW, 19, BRAM address width
DW, 16, pixel width (RGB565)
NPIX, 307200, frame size in pixels (640x480); valid addresses 0..NPIX-1
RD_LAT, 1, BRAM read latency in cycles (1..3)

Ports:
CLK  in  1  clock (pixel and BRAM clock)
RESET  in  1  asynchronous, active-high reset
disp_en  in  1  scanout read request (active-video DE), one pixel per cycle
disp_addr  in  AW  scanout read address
disp_rdata  out  DW  scanout pixel, equal to bram_rdata
disp_rvalid  out  1  disp_en delayed by RD_LAT cycles
wr_valid  in  1  writer request
wr_ready  out  1  writer may transfer this cycle
wr_addr  in  AW  writer address
wr_data  in  DW  writer pixel
wr_err  out  1  registered 1-cycle pulse: accepted write had address >= NPIX
clr_start  in  1  start clear (level sampled when engine is idle)
clr_color  in  DW  fill colour, captured when clr_start is accepted
clr_busy  out  1  clear engine active
clr_done  out  1  registered 1-cycle pulse after the last clear write
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  AW  BRAM address
bram_wdata  out  DW  BRAM write data
bram_rdata  in  DW  BRAM read data

Behaviour:
- Reset values: clr_busy=0, clr_done=0, wr_err=0, disp_rvalid pipeline=0, FSM=IDLE, clear address=0, latched colour=0.
- While RESET is high: wr_ready=0, bram_en=0, bram_we=0.
- BRAM port is a combinational mux, priority disp > clear > writer:
  - disp_en=1: en=1, we=0, addr=disp_addr.
  - else clr_busy=1: en=1, we=1, addr=clear address, wdata=latched colour.
  - else wr_valid=1 and wr_addr<NPIX: en=1, we=1, addr=wr_addr, wdata=wr_data.
  - otherwise: en=0, we=0, addr=0, wdata=0.
- wr_ready = !RESET && !disp_en && !clr_busy (combinational).
- Write transfer occurs on wr_valid && wr_ready.
- Out-of-range transfer: accepted (consumed), not written to BRAM, wr_err pulses the following cycle.
- disp_rvalid: shift register of depth RD_LAT fed by disp_en. disp_rdata passes bram_rdata through.
- Clear FSM states:
  - IDLE: clr_start=1 goes to CLEAR, clear address=0, clr_color latched.
  - CLEAR: clr_busy=1. Each cycle with disp_en=0 writes one pixel and increments the address. The write at address NPIX-1 goes to DONE. Cycles with disp_en=1 stall the engine with no increment.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then go to IDLE.
- clr_start while in CLEAR or DONE is ignored. clr_start held high restarts the engine on the cycle after DONE.
- Simultaneous disp_en and wr_valid: writer stalls, with wr_ready=0 that cycle.
- Simultaneous clr_start and writer transfer in IDLE: the write completes this cycle; the clear owns the port from the next cycle.
- RESET asserted mid-clear: FSM returns to IDLE, the remaining pixels are not written, and clr_done does not pulse.
- Address counters are AW bits wide. The clear counter never exceeds NPIX-1; no wrap.

Optional Feature:
FB_ARB_STATS_EN
- Defined:
  - Adds outputs wr_stall_cnt[31:0] and disp_clr_collide_cnt[31:0], both reset to 0 and saturating at 2^32-1.
  - wr_stall_cnt increments each cycle with wr_valid=1 and wr_ready=0.
  - disp_clr_collide_cnt increments each cycle with clr_busy=1 and disp_en=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fb_pkg holds:
  - constants FB_HSIZE=640, FB_VSIZE=480, FB_NPIX, FB_AW, FB_DW;
  - clear-FSM state enum clr_state_t {IDLE, CLEAR, DONE};
  - RGB565 pixel typedef.
- One natural sub-module: fb_clear_engine (FSM, address counter, colour latch, busy/done). The top level holds the priority mux, handshake and rvalid pipeline.

Test Plan:
1. Reset, then disp_en=1 for 640 cycles with disp_addr 0..639 -> bram_we=0 throughout; disp_rvalid rises RD_LAT cycles after disp_en and stays high 640 cycles.
2. wr_valid=1, wr_addr=100, wr_data=16'hF800 with disp_en=0 -> transfer in one cycle, bram_we=1, bram_addr=100; later read of 100 returns F800.
3. wr_valid=1 held during disp_en=1 burst of 10 cycles -> wr_ready=0 for all 10 cycles, transfer on the first cycle after; wr_stall_cnt=10 when FB_ARB_STATS_EN is defined.
4. clr_start with clr_color=16'h07E0, NPIX=16 override, disp_en pattern 1-of-3 cycles -> 16 writes, addresses 0..15 in order, no write on disp cycles, single clr_done pulse.
5. wr_valid=1, wr_addr=NPIX (307200) -> wr_ready=1, bram_en=0, wr_err pulses once next cycle.
6. RESET asserted after 5 clear writes -> clr_busy=0 immediately, no clr_done; a new clr_start restarts from address 0.
